muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_div_iter.sv | 58 +++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_e;

    function automatic logic is_div(funct3_e f);
        logic [2:0] v;
        v = f;
        return v[2];
    endfunction

    function automatic logic op_signed_a(funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic op_signed_b(funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wrt_addr;
    logic            en;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_addr,
        input  busy, done, result, wrt_addr, en
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_addr,
        output busy, done, result, wrt_addr, en
    );

endinterface

// File: rtl/muldiv_div_iter.sv
// Restoring divider step register: one quotient bit per step on unsigned magnitudes.
module div_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = $clog2(ITER_COUNT);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [CW-1:0]   count_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // A clear top bit of diff means the trial subtraction did not borrow.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            quo_q   <= dividend;
            rem_q   <= '0;
            dsr_q   <= divisor;
            count_q <= '0;
        end else if (step) begin
            count_q <= count_q + 1'b1;
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (count_q == CW'(ITER_COUNT - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide with sign fixup.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiply.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    state_e          state;
    funct3_e         op_q;
    funct3_e         op_in;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mul_hi_q;
    logic [XLEN-1:0] mul_lo_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            div_zero_q;
    logic            ovf_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            in_zero;
    logic            in_ovf;
    logic            accept;
    logic            fast_mul;
    logic [2*XLEN-1:0] fast_prod;

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            div_last;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] fix_result;

    // Both datapaths work on magnitudes; the signs are reapplied in FIXUP.
    always_comb begin
        op_in   = funct3_e'(bus.funct3);
        a_neg   = op_signed_a(op_in) && bus.rs1_val[XLEN-1];
        b_neg   = op_signed_b(op_in) && bus.rs2_val[XLEN-1];
        a_mag   = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag   = b_neg ? -bus.rs2_val : bus.rs2_val;
        in_zero = is_div(op_in) && (bus.rs2_val == '0);
        in_ovf  = ((op_in == F3_DIV) || (op_in == F3_REM)) &&
                  (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
        accept  = (state == S_IDLE) && bus.start;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN+1:0] fast_full;

    always_comb begin
        fast_a    = $signed({op_signed_a(op_in) & bus.rs1_val[XLEN-1], bus.rs1_val});
        fast_b    = $signed({op_signed_b(op_in) & bus.rs2_val[XLEN-1], bus.rs2_val});
        fast_full = fast_a * fast_b;
        fast_prod = fast_full[2*XLEN-1:0];
        fast_mul  = !is_div(op_in);
    end
`else
    always_comb begin
        fast_prod = '0;
        fast_mul  = 1'b0;
    end
`endif

    div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      (state == S_CALC),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    always_comb begin
        mul_sum  = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mcand_q} : '0);
        prod_raw = {mul_hi_q, mul_lo_q};
        prod_fix = neg_res_q ? -prod_raw : prod_raw;
        case (op_q)
            F3_MUL:                        fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (div_zero_q)     fix_result = '1;
                else if (ovf_q)     fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else if (neg_res_q) fix_result = -quo;
                else                fix_result = quo;
            end
            default: begin
                if (div_zero_q)     fix_result = rs1_q;
                else if (ovf_q)     fix_result = '0;
                else if (neg_rem_q) fix_result = -rem;
                else                fix_result = rem;
            end
        endcase
    end

    // Divide-by-zero, signed overflow and fast multiplies skip CALC entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.en       <= 1'b0;
            bus.result   <= '0;
            bus.wrt_addr <= '0;
            op_q         <= F3_MUL;
            rd_q         <= '0;
            rs1_q        <= '0;
            mcand_q      <= '0;
            mul_hi_q     <= '0;
            mul_lo_q     <= '0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.en   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q       <= op_in;
                        rd_q       <= bus.rd_addr;
                        rs1_q      <= bus.rs1_val;
                        mcand_q    <= a_mag;
                        neg_res_q  <= fast_mul ? 1'b0 : (a_neg ^ b_neg);
                        neg_rem_q  <= a_neg;
                        div_zero_q <= in_zero;
                        ovf_q      <= in_ovf;
                        bus.busy   <= 1'b1;
                        if (fast_mul) begin
                            {mul_hi_q, mul_lo_q} <= fast_prod;
                            state                <= S_FIXUP;
                        end else begin
                            mul_hi_q <= '0;
                            mul_lo_q <= b_mag;
                            state    <= (in_zero || in_ovf) ? S_FIXUP : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    mul_hi_q <= mul_sum[XLEN:1];
                    mul_lo_q <= {mul_sum[0], mul_lo_q[XLEN-1:1]};
                    if (div_last) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    bus.result   <= fix_result;
                    bus.wrt_addr <= rd_q;
                    bus.done     <= 1'b1;
                    bus.en       <= (rd_q != 5'd0);
                    state        <= S_DONE;
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized back-to-back ops, reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    muldiv_if bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9] = '{
        '{3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB},
        '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE},
        '{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2,  32'h00000000},
        '{3'b100, 32'hFFFFFFF9,  32'd2,        5'd3,  32'hFFFFFFFD},
        '{3'b110, 32'hFFFFFFF9,  32'd2,        5'd4,  32'hFFFFFFFF},
        '{3'b101, 32'd100,       32'd0,        5'd6,  32'hFFFFFFFF},
        '{3'b111, 32'd100,       32'd0,        5'd7,  32'd100},
        '{3'b100, 32'h80000000,  32'hFFFFFFFF, 5'd8,  32'h80000000},
        '{3'b110, 32'h80000000,  32'hFFFFFFFF, 5'd9,  32'h00000000}
    };

    // Reference model: plain 64-bit integer arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_result(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] ua;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'b0, b};
        ua = {32'b0, a};
        ia = a;
        ib = b;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 2;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op in an IDLE cycle, scrambles the inputs afterwards, and waits for done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int glitch_at,
                         output int lat, output logic [31:0] res, output logic [4:0] wa,
                         output logic en_o, output logic busy1);
        lat   = 0;
        res   = '0;
        wa    = '0;
        en_o  = 1'b0;
        busy1 = 1'b0;
        @(posedge clk);
        #1;
        bus.funct3  = f;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_addr = rd;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.funct3  = 3'($urandom);
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_addr = 5'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = bus.busy;
            if (bus.done) begin
                lat  = c;
                res  = bus.result;
                wa   = bus.wrt_addr;
                en_o = bus.en;
                break;
            end
            bus.start = (c == glitch_at);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.funct3  = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        n_vec++; if (bus.en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_en: got %b expected 0", bus.en); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
        n_vec++; if (bus.wrt_addr !== 5'h0) begin n_err++; $display("[TB] FAIL reset_wrt_addr: got %h expected 0", bus.wrt_addr); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_directed();
        int          lat;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        en_o;
        logic        busy1;
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, 0, lat, res, wa, en_o, busy1);
            n_vec++; if (res !== tbl[i].exp) begin n_err++; $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, tbl[i].exp); end
            n_vec++; if (lat !== ref_latency(tbl[i].f, tbl[i].a, tbl[i].b)) begin n_err++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, ref_latency(tbl[i].f, tbl[i].a, tbl[i].b)); end
            n_vec++; if (wa !== tbl[i].rd) begin n_err++; $display("[TB] FAIL directed_wrt_addr[%0d]: got %0d expected %0d", i, wa, tbl[i].rd); end
            n_vec++; if (en_o !== 1'b1) begin n_err++; $display("[TB] FAIL directed_en[%0d]: got %b expected 1", i, en_o); end
            n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("[TB] FAIL directed_busy[%0d]: got %b expected 1", i, busy1); end
        end
    endtask

    task automatic test_rd_zero_and_hold();
        int          lat;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        en_o;
        logic        busy1;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        do_op(3'b000, a, b, 5'd0, 0, lat, res, wa, en_o, busy1);
        n_vec++; if (res !== ref_result(3'b000, a, b)) begin n_err++; $display("[TB] FAIL rd0_result: got %h expected %h", res, ref_result(3'b000, a, b)); end
        n_vec++; if (en_o !== 1'b0) begin n_err++; $display("[TB] FAIL rd0_en: got %b expected 0", en_o); end
        n_vec++; if (wa !== 5'd0) begin n_err++; $display("[TB] FAIL rd0_wrt_addr: got %0d expected 0", wa); end
        do_op(3'b101, 32'd1000, 32'd7, 5'd17, 0, lat, res, wa, en_o, busy1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("[TB] FAIL hold_done[%0d]: got %b expected 0", k, bus.done); end
            n_vec++; if (bus.en !== 1'b0) begin n_err++; $display("[TB] FAIL hold_en[%0d]: got %b expected 0", k, bus.en); end
            n_vec++; if (bus.result !== 32'd142) begin n_err++; $display("[TB] FAIL hold_result[%0d]: got %h expected %h", k, bus.result, 32'd142); end
            n_vec++; if (bus.wrt_addr !== 5'd17) begin n_err++; $display("[TB] FAIL hold_wrt_addr[%0d]: got %0d expected 17", k, bus.wrt_addr); end
        end
    endtask

    task automatic test_busy_ignore();
        int          lat;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        en_o;
        logic        busy1;
        logic        extra;
        do_op(3'b100, 32'hFFFFFF00, 32'd9, 5'd12, 5, lat, res, wa, en_o, busy1);
        n_vec++; if (res !== ref_result(3'b100, 32'hFFFFFF00, 32'd9)) begin n_err++; $display("[TB] FAIL ignore_result: got %h expected %h", res, ref_result(3'b100, 32'hFFFFFF00, 32'd9)); end
        n_vec++; if (lat !== 34) begin n_err++; $display("[TB] FAIL ignore_latency: got %0d expected 34", lat); end
        extra = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) extra = 1'b1;
        end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_second_done: got %b expected 0", extra); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_op();
        int          lat;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        en_o;
        logic        busy1;
        logic        spurious;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom & 32'h7FFFFFFF;
        b = $urandom | 32'h1;
        @(posedge clk);
        #1;
        bus.funct3  = 3'b100;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_addr = 5'd20;
        bus.start   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("[TB] FAIL abort_result: got %h expected 0", bus.result); end
        n_vec++; if (bus.wrt_addr !== 5'h0) begin n_err++; $display("[TB] FAIL abort_wrt_addr: got %0d expected 0", bus.wrt_addr); end
        spurious = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.en) spurious = 1'b1;
        end
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_done: got %b expected 0", spurious); end
        do_op(3'b110, a, b, 5'd21, 0, lat, res, wa, en_o, busy1);
        n_vec++; if (res !== ref_result(3'b110, a, b)) begin n_err++; $display("[TB] FAIL abort_next_result: got %h expected %h", res, ref_result(3'b110, a, b)); end
        n_vec++; if (lat !== 34) begin n_err++; $display("[TB] FAIL abort_next_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_random_back_to_back();
        int          lat;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        en_o;
        logic        busy1;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            do_op(f, a, b, rd, 0, lat, res, wa, en_o, busy1);
            n_vec++; if (res !== ref_result(f, a, b)) begin n_err++; $display("[TB] FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, ref_result(f, a, b)); end
            n_vec++; if (lat !== ref_latency(f, a, b)) begin n_err++; $display("[TB] FAIL rand_latency[%0d] f=%0d: got %0d expected %0d", i, f, lat, ref_latency(f, a, b)); end
            n_vec++; if (wa !== rd) begin n_err++; $display("[TB] FAIL rand_wrt_addr[%0d]: got %0d expected %0d", i, wa, rd); end
            n_vec++; if (en_o !== (rd != 5'd0)) begin n_err++; $display("[TB] FAIL rand_en[%0d]: got %b expected %b", i, en_o, (rd != 5'd0)); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_rd_zero_and_hold();
        test_busy_ignore();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
